// File: rtl/if1_fetch_packer.sv
// ---------------------------------------------------------------------------
// if1_fetch_packer
//
// Second fetch stage (IF1). It takes one fetch request's metadata from IF0
// and waits for the ICache data beat. It then aligns the fetched slots from
// the PC word offset and packs them low-first toward the instruction buffer.
// When the IB has less room than the fetched group, the residue is held
// internally and drained over later cycles. A flush that arrives while the
// ICache response is still outstanding parks the stage in KILL until that
// stale beat shows up, then discards it.
//
// Optional build macro: IF1_JUMP_TRUNC_EN
//   defined   : the group ends at the first predicted-taken slot at or after
//               the PC offset; later slots are never pushed.
//   undefined : the group always runs to the end of the fetch line.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_IF        kill the current request and any held data
//   in_valid        IF0 metadata valid
//   in_ready        IF1 accepts metadata this cycle
//   in_pc           fetch PC (word aligned)
//   in_valid_mask   per-slot valid bits
//   in_jump_mask    per-slot predicted-taken bits
//   data_ok         ICache data beat
//   rdata           fetch line; slot i at rdata[32i +: 32]
//   can_push_size   free IB entries
//   push_num        entries pushed this cycle
//   push_data       packed entries, entry k at [k*ENTRY_WD +: ENTRY_WD],
//                   layout {valid, is_jump, pc[31:0], instr[31:0]}
// ---------------------------------------------------------------------------
module if1_fetch_packer #(
    parameter  int FETCH_WIDTH   = 4,
    parameter  int IB_DEPTH_LOG2 = 4,
    localparam int LFW           = $clog2(FETCH_WIDTH),
    localparam int ENTRY_WD      = 66
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_IF,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [31:0]                     in_pc,
    input  logic [FETCH_WIDTH-1:0]          in_valid_mask,
    input  logic [FETCH_WIDTH-1:0]          in_jump_mask,
    input  logic                            data_ok,
    input  logic [32*FETCH_WIDTH-1:0]       rdata,
    input  logic [IB_DEPTH_LOG2:0]          can_push_size,
    output logic [LFW:0]                    push_num,
    output logic [FETCH_WIDTH*ENTRY_WD-1:0] push_data
);

    // Common width used for the min(rem, can_push_size) comparison.
    localparam int CW = ((LFW + 1) > (IB_DEPTH_LOG2 + 1)) ? (LFW + 1) : (IB_DEPTH_LOG2 + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_KILL  = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [29-LFW:0]             r_pc_hi;
    logic [LFW-1:0]              r_ptr;
    logic [LFW:0]                r_rem;
    logic [FETCH_WIDTH-1:0]      r_vmask;
    logic [FETCH_WIDTH-1:0]      r_jmask;
    logic [32*FETCH_WIDTH-1:0]   r_line;

    logic [LFW-1:0]              w_off;
    logic [LFW:0]                w_cnt;
    logic [CW-1:0]               w_rem_x;
    logic [CW-1:0]               w_cps_x;
    logic [CW-1:0]               w_n_x;
    logic [LFW:0]                w_n;
    logic                        w_done;
    logic                        w_push_en;
    logic [32*FETCH_WIDTH-1:0]   w_src;
    logic                        w_unused;

    assign w_unused = ^in_pc[1:0];

    assign w_off = in_pc[LFW+1:2];

    // Group size for the incoming request.
    always_comb begin
        w_cnt = (LFW+1)'(FETCH_WIDTH) - {1'b0, w_off};
`ifdef IF1_JUMP_TRUNC_EN
        begin : jump_trunc
            logic w_found;
            w_found = 1'b0;
            for (int s = 0; s < FETCH_WIDTH; s++) begin
                if (!w_found && (s >= int'(w_off)) && in_jump_mask[s]) begin
                    w_cnt   = (LFW+1)'(s - int'(w_off) + 1);
                    w_found = 1'b1;
                end
            end
        end
`endif
    end

    // n = min(rem, can_push_size); n never exceeds rem, so it fits LFW+1 bits.
    assign w_rem_x = CW'(r_rem);
    assign w_cps_x = CW'(can_push_size);
    assign w_n_x   = (w_rem_x < w_cps_x) ? w_rem_x : w_cps_x;
    assign w_n     = (LFW+1)'(w_n_x);
    assign w_done  = (w_n == r_rem);

    assign in_ready  = (r_state == S_IDLE) & ~flush_IF & ~rst;
    assign w_push_en = ~rst & ~flush_IF &
                       (((r_state == S_WAIT) & data_ok) | (r_state == S_DRAIN));
    assign push_num  = w_push_en ? w_n : '0;

    // WAIT forwards the live beat with zero latency; DRAIN reads the held copy.
    assign w_src = (r_state == S_WAIT) ? rdata : r_line;

    // Entry k carries slot ptr+k. ptr+rem never exceeds FETCH_WIDTH, so the
    // slot index cannot wrap for any k below push_num.
    always_comb begin
        push_data = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            logic [LFW-1:0] w_slot;
            w_slot = r_ptr + LFW'(k);
            if (k < int'(push_num)) begin
                push_data[k*ENTRY_WD +: ENTRY_WD] = {r_vmask[w_slot], r_jmask[w_slot],
                                                     r_pc_hi, w_slot, 2'b00,
                                                     w_src[32*int'(w_slot) +: 32]};
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!flush_IF && in_valid)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (flush_IF)
                    w_state_nxt = data_ok ? S_IDLE : S_KILL;
                else if (data_ok)
                    w_state_nxt = w_done ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (flush_IF || w_done)
                    w_state_nxt = S_IDLE;
            end
            S_KILL: begin
                // The outstanding beat belongs to the killed request.
                if (!flush_IF && data_ok)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc_hi <= '0;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_vmask <= '0;
            r_jmask <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_IF) begin
                r_rem <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (in_valid) begin
                            r_pc_hi <= in_pc[31:LFW+2];
                            r_ptr   <= w_off;
                            r_rem   <= w_cnt;
                            r_vmask <= in_valid_mask;
                            r_jmask <= in_jump_mask;
                        end
                    end
                    S_WAIT: begin
                        if (data_ok) begin
                            r_rem <= r_rem - w_n;
                            r_ptr <= r_ptr + w_n[LFW-1:0];
                            if (!w_done)
                                r_line <= rdata;
                        end
                    end
                    S_DRAIN: begin
                        r_rem <= r_rem - w_n;
                        r_ptr <= r_ptr + w_n[LFW-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
